// File: rtl/gpio_pad_ctrl.sv
// GPIO pad bank controller: pad output/enable registers, input synchroniser and edge interrupts.
// Optional per-bit glitch filter on the synchronised inputs when GPIO_PAD_CTRL_FILTER_EN is defined.
module gpio_pad_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             irq,
    output logic [WIDTH-1:0] pad_dout,
    output logic [WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0] pad_ie,
    output logic [WIDTH-1:0] pad_puen,
    input  logic [WIDTH-1:0] pad_di
);

    logic [WIDTH-1:0] reg_dout;
    logic [WIDTH-1:0] reg_oe;
    logic [WIDTH-1:0] reg_ie;
    logic [WIDTH-1:0] reg_puen;
    logic [WIDTH-1:0] reg_irq_en;
    logic [WIDTH-1:0] reg_irq_pol;
    logic [WIDTH-1:0] reg_irq_stat;

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] ie_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] wr_val;
    logic [31:0]      rd_val;
    logic             wr_en;
    logic             rd_en;

    assign wr_en  = sel & we;
    assign rd_en  = sel & ~we;
    assign wr_val = wdata[WIDTH-1:0];
    assign w1c    = (wr_en && addr == 3'd7) ? wr_val : '0;

    // ie_d gates out the false edge produced when an input enable is switched on
    assign edge_det = reg_ie & ie_d &
                      ((reg_irq_pol & filt & ~prev) | (~reg_irq_pol & ~filt & prev));

    assign pad_dout = reg_dout;
    assign pad_oe   = reg_oe;
    assign pad_ie   = reg_ie;
    assign pad_puen = reg_puen;
    assign irq      = |(reg_irq_stat & reg_irq_en);

    always_comb begin
        rd_val = '0;
        case (addr)
            3'd0: rd_val[WIDTH-1:0] = reg_dout;
            3'd1: rd_val[WIDTH-1:0] = reg_oe;
            3'd2: rd_val[WIDTH-1:0] = reg_ie;
            3'd3: rd_val[WIDTH-1:0] = reg_puen;
            3'd4: rd_val[WIDTH-1:0] = filt;
            3'd5: rd_val[WIDTH-1:0] = reg_irq_en;
            3'd6: rd_val[WIDTH-1:0] = reg_irq_pol;
            3'd7: rd_val[WIDTH-1:0] = reg_irq_stat;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_dout     <= '0;
            reg_oe       <= '0;
            reg_ie       <= '0;
            reg_puen     <= '0;
            reg_irq_en   <= '0;
            reg_irq_pol  <= '1;
            reg_irq_stat <= '0;
            rdata        <= '0;
            sync_meta    <= '0;
            sync         <= '0;
            prev         <= '0;
            ie_d         <= '0;
        end else begin
            if (wr_en) begin
                case (addr)
                    3'd0: reg_dout    <= wr_val;
                    3'd1: reg_oe      <= wr_val;
                    3'd2: reg_ie      <= wr_val;
                    3'd3: reg_puen    <= wr_val;
                    3'd5: reg_irq_en  <= wr_val;
                    3'd6: reg_irq_pol <= wr_val;
                    default: ;
                endcase
            end
            // a new edge takes priority over a simultaneous clear
            reg_irq_stat <= (reg_irq_stat & ~w1c) | edge_det;
            if (rd_en) begin
                rdata <= rd_val;
            end
            sync_meta <= pad_di;
            sync      <= sync_meta;
            prev      <= filt;
            ie_d      <= reg_ie;
        end
    end

`ifdef GPIO_PAD_CTRL_FILTER_EN
    logic [1:0] flt_cnt [WIDTH];

    // filt follows sync only after sync has differed from it for four consecutive cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                flt_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync[i] != filt[i]) begin
                    if (flt_cnt[i] == 2'd3) begin
                        filt[i]    <= sync[i];
                        flt_cnt[i] <= 2'd0;
                    end else begin
                        flt_cnt[i] <= flt_cnt[i] + 2'd1;
                    end
                end else begin
                    flt_cnt[i] <= 2'd0;
                end
            end
        end
    end
`else
    assign filt = sync;
`endif

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Scoreboard bench for gpio_pad_ctrl (WIDTH=8): stimulus queues expected values,
// a monitor pops and compares whenever a read or probe cycle completes.
module tb_gpio_pad_ctrl;

`ifdef GPIO_PAD_CTRL_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  pad_dout;
    logic [7:0]  pad_oe;
    logic [7:0]  pad_ie;
    logic [7:0]  pad_puen;
    logic [7:0]  pad_di;
    logic        probe_r;

    typedef struct {
        string       name;
        int          src;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    gpio_pad_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .irq      (irq),
        .pad_dout (pad_dout),
        .pad_oe   (pad_oe),
        .pad_ie   (pad_ie),
        .pad_puen (pad_puen),
        .pad_di   (pad_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] e);
        n_cmp++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, e);
        end
    endtask

    function automatic logic [31:0] observe(input int src);
        case (src)
            0:       return rdata;
            1:       return {31'd0, irq};
            2:       return {24'd0, pad_dout};
            3:       return {24'd0, pad_oe};
            4:       return {24'd0, pad_ie};
            default: return {24'd0, pad_puen};
        endcase
    endfunction

    // monitor: a read or probe cycle presents an output just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && ((sel && !we) || probe_r)) begin
                #1;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got 0x%08h, expected nothing queued", rdata);
                end else begin
                    e = sbq.pop_front();
                    cmp(e.name, observe(e.src), e.exp);
                end
            end
        end
    end

    task automatic push(input int src, input logic [31:0] e, input string nm);
        exp_t x;
        x.name = nm;
        x.src  = src;
        x.exp  = e;
        sbq.push_back(x);
    endtask

    // all tasks start and end on a falling edge
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        push(0, e, nm);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic probe(input int src, input logic [31:0] e, input string nm);
        push(src, e, nm);
        probe_r = 1'b1;
        @(negedge clk);
        probe_r = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0; we = 1'b0; addr = 3'd0; wdata = 32'd0;
        pad_di = 8'h00; probe_r = 1'b0;
        idle(3);
        rst_n = 1'b1;

        rd(3'd6, 32'h0000_00FF, "rst_irq_pol");
        rd(3'd0, 32'h0, "rst_dout");
        rd(3'd7, 32'h0, "rst_irq_stat");
        rd(3'd5, 32'h0, "rst_irq_en");
        probe(1, 32'h0, "rst_irq");

        // output path
        wr(3'd0, 32'h0000_00A5); probe(2, 32'hA5, "pad_dout");
        wr(3'd1, 32'h0000_000F); probe(3, 32'h0F, "pad_oe");
        wr(3'd3, 32'h0000_0030); probe(5, 32'h30, "pad_puen");
        rd(3'd0, 32'h0000_00A5, "rb_dout");
        rd(3'd1, 32'h0000_000F, "rb_oe");
        rd(3'd3, 32'h0000_0030, "rb_puen");
        wr(3'd0, 32'hFFFF_FF5A);
        rd(3'd0, 32'h0000_005A, "dout_upper_ignored");
        probe(2, 32'h5A, "pad_dout_5a");
        wr(3'd4, 32'h0000_00FF);
        rd(3'd4, 32'h0, "din_write_ignored");

        // input synchroniser latency
        wr(3'd2, 32'h0000_00FF); probe(4, 32'hFF, "pad_ie");
        idle(2);
        pad_di = 8'h3C;
        for (int i = 0; i < LAT; i++) rd(3'd4, 32'h0, "din_latency");
        rd(3'd4, 32'h0000_003C, "din_value");
`ifdef GPIO_PAD_CTRL_FILTER_EN
        pad_di[0] = 1'b1;
        idle(3);
        pad_di[0] = 1'b0;
        for (int i = 0; i < 10; i++) rd(3'd4, 32'h0000_003C, "din_glitch_filtered");
`endif
        idle(2);
        rd(3'd7, 32'h0000_003C, "stat_rise_default_pol");
        probe(1, 32'h0, "irq_masked_reset_en");
        wr(3'd7, 32'h0000_00FF);
        rd(3'd7, 32'h0, "stat_w1c_all");

        // rising interrupt
        pad_di = 8'h00;
        wr(3'd2, 32'h01); wr(3'd5, 32'h01); wr(3'd6, 32'h01);
        idle(LAT + 2);
        rd(3'd7, 32'h0, "no_fall_with_rise_pol");
        pad_di = 8'h01;
        idle(LAT);
        probe(1, 32'h1, "irq_rise");
        rd(3'd7, 32'h01, "stat_rise");
        wr(3'd7, 32'h01);
        probe(1, 32'h0, "irq_cleared");

        // clear colliding with a new edge
        pad_di = 8'h00; idle(LAT + 2);
        pad_di = 8'h01; idle(LAT + 2);
        pad_di = 8'h00; idle(LAT + 2);
        pad_di = 8'h01;
        idle(LAT);
        wr(3'd7, 32'h01);
        rd(3'd7, 32'h01, "w1c_edge_collision");
        wr(3'd7, 32'h01);
        rd(3'd7, 32'h0, "w1c_plain");

        // falling interrupt, masked then unmasked
        wr(3'd6, 32'h00); wr(3'd5, 32'h00); wr(3'd2, 32'h04);
        pad_di = 8'h04;
        idle(LAT + 2);
        rd(3'd7, 32'h0, "no_rise_with_fall_pol");
        pad_di = 8'h00;
        idle(LAT);
        probe(1, 32'h0, "irq_masked_by_en");
        rd(3'd7, 32'h04, "stat_fall");
        wr(3'd5, 32'h04);
        probe(1, 32'h1, "irq_unmasked");

        // asynchronous reset mid-cycle
        wr(3'd0, 32'h81);
        rd(3'd0, 32'h81, "rb_dout_before_reset");
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rst_pad_dout", {24'd0, pad_dout}, 32'h0);
        cmp("async_rst_pad_oe",   {24'd0, pad_oe},   32'h0);
        cmp("async_rst_pad_ie",   {24'd0, pad_ie},   32'h0);
        cmp("async_rst_pad_puen", {24'd0, pad_puen}, 32'h0);
        cmp("async_rst_rdata",    rdata,             32'h0);
        cmp("async_rst_irq",      {31'd0, irq},      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(3'd6, 32'h0000_00FF, "pol_after_reset");
        rd(3'd7, 32'h0, "stat_after_reset");

        // enabling an input that is already high must not look like an edge
        pad_di = 8'h02;
        wr(3'd6, 32'h02); wr(3'd5, 32'h02);
        idle(LAT + 2);
        wr(3'd2, 32'h02);
        idle(LAT + 2);
        rd(3'd7, 32'h0, "ie_toggle_no_edge");
        probe(1, 32'h0, "ie_toggle_no_irq");
        rd(3'd4, 32'h02, "din_bit1");

        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
